// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the mian multi-cycle control path and its datapath.
package mips_ctrl_pkg;

  localparam int unsigned OPCODE_W   = 6;
  localparam int unsigned FUNCT_W    = 6;
  localparam int unsigned STATE_W    = 4;
  localparam int unsigned ALU_CTRL_W = 3;
  localparam int unsigned SEL_W      = 2;
  localparam int unsigned COUNT_W    = 32;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;

  localparam logic [FUNCT_W-1:0] FN_ADD = 6'b100000;
  localparam logic [FUNCT_W-1:0] FN_SUB = 6'b100010;
  localparam logic [FUNCT_W-1:0] FN_AND = 6'b100100;
  localparam logic [FUNCT_W-1:0] FN_OR  = 6'b100101;
  localparam logic [FUNCT_W-1:0] FN_SLT = 6'b101010;

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 3'b010;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 3'b110;
  localparam logic [ALU_CTRL_W-1:0] ALU_AND = 3'b000;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 3'b001;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT = 3'b111;

  localparam logic [SEL_W-1:0] SRCB_B       = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_FOUR    = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_IMM     = 2'b10;
  localparam logic [SEL_W-1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'b00;
  localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// R-type funct field to ALU operation; funct_ok flags the supported subset.
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [FUNCT_W-1:0]    funct,
  output logic [ALU_CTRL_W-1:0] alu_ctrl,
  output logic                  funct_ok
);

  always_comb begin
    alu_ctrl = ALU_AND;
    funct_ok = 1'b1;
    case (funct)
      FN_ADD:  alu_ctrl = ALU_ADD;
      FN_SUB:  alu_ctrl = ALU_SUB;
      FN_AND:  alu_ctrl = ALU_AND;
      FN_OR:   alu_ctrl = ALU_OR;
      FN_SLT:  alu_ctrl = ALU_SLT;
      default: funct_ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WB sequencer with memory stall,
// retired-instruction counter and sticky illegal-instruction trap.
module multicycle_ctrl
  import mips_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [OPCODE_W-1:0]   opcode,
  input  logic [FUNCT_W-1:0]    funct,
  input  logic                  zero,
  input  logic                  mem_ready,
  output logic                  pc_en,
  output logic                  iord,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  ir_write,
  output logic                  reg_dst,
  output logic                  mem_to_reg,
  output logic                  reg_write,
  output logic                  alu_src_a,
  output logic [SEL_W-1:0]      alu_src_b,
  output logic [ALU_CTRL_W-1:0] alu_ctrl,
  output logic [SEL_W-1:0]      pc_src,
  output logic [STATE_W-1:0]    state,
  output logic                  trap,
  output logic [COUNT_W-1:0]    retired
);

  state_t                state_q, state_d;
  logic [COUNT_W-1:0]    retired_q;
  logic [ALU_CTRL_W-1:0] funct_alu;
  logic                  funct_ok;
  logic                  retire_c;

  alu_decoder u_alu_decoder (
    .funct    (funct),
    .alu_ctrl (funct_alu),
    .funct_ok (funct_ok)
  );

  // State register and retired counter; a trapped instruction never reaches a retire state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire_c) retired_q <= retired_q + COUNT_W'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    retire_c   = 1'b0;
    pc_en      = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_B;
    alu_ctrl   = ALU_AND;
    pc_src     = PCSRC_ALU;
    trap       = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        alu_ctrl  = ALU_ADD;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH2;
        alu_ctrl  = ALU_ADD;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEMADR, S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_ctrl  = ALU_ADD;
        if (state_q == S_ADDIEX) state_d = S_ADDIWB;
        else                     state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire_c   = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        retire_c  = mem_ready;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_ctrl  = funct_alu;
        state_d   = funct_ok ? S_ALUWB : S_TRAP;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire_c  = 1'b1;
        state_d   = S_FETCH;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
        retire_c  = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_ctrl  = ALU_SUB;
        pc_src    = PCSRC_ALUOUT;
        pc_en     = zero;
        retire_c  = 1'b1;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pc_src   = PCSRC_JUMP;
        pc_en    = 1'b1;
        retire_c = 1'b1;
        state_d  = S_FETCH;
      end
      S_TRAP: begin
        trap    = 1'b1;
        state_d = S_TRAP;
      end
      default: state_d = S_TRAP;
    endcase

    // No architectural write may escape in a reset cycle.
    if (reset) begin
      pc_en     = 1'b0;
      ir_write  = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
    end
  end

  assign state   = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed scenarios plus random instruction stream.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset, zero, mem_ready;
  logic [5:0]  opcode, funct;
  logic        pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, trap;
  logic [1:0]  alu_src_b, pc_src;
  logic [2:0]  alu_ctrl;
  logic [3:0]  state;
  logic [31:0] retired;

  int n_cmp = 0;
  int n_bad = 0;
  int model_ret = 0;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_en(pc_en), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .pc_src(pc_src),
    .state(state), .trap(trap), .retired(retired)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] alu_of(input logic [5:0] fn);
    case (fn)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b000;
    endcase
  endfunction

  function automatic bit funct_legal(input logic [5:0] fn);
    return fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  endfunction

  // Output table per state: {pc_en,iord,mem_read,mem_write,ir_write,reg_dst,mem_to_reg,reg_write,alu_src_a,alu_src_b,alu_ctrl,pc_src,trap}
  function automatic logic [16:0] exp_out(input int st, input logic mr, input logic z,
                                          input logic rs, input logic [5:0] fn);
    logic pe, io, rd, wr, irw, rdst, m2r, rw, sa, tr;
    logic [1:0] sb, ps;
    logic [2:0] ac;
    pe = 0; io = 0; rd = 0; wr = 0; irw = 0; rdst = 0; m2r = 0; rw = 0; sa = 0; tr = 0;
    sb = 2'b00; ps = 2'b00; ac = 3'b000;
    case (st)
      0:  begin rd = 1; sb = 2'b01; ac = 3'b010; irw = mr; pe = mr; end
      1:  begin sb = 2'b11; ac = 3'b010; end
      2, 9: begin sa = 1; sb = 2'b10; ac = 3'b010; end
      3:  begin rd = 1; io = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin wr = 1; io = 1; end
      6:  begin sa = 1; ac = alu_of(fn); end
      7:  begin rw = 1; rdst = 1; end
      8:  begin sa = 1; ac = 3'b110; ps = 2'b01; pe = z; end
      10: begin rw = 1; end
      11: begin ps = 2'b10; pe = 1; end
      12: begin tr = 1; end
      default: ;
    endcase
    if (rs) begin pe = 0; irw = 0; rd = 0; wr = 0; rw = 0; end
    return {pe, io, rd, wr, irw, rdst, m2r, rw, sa, sb, ac, ps, tr};
  endfunction

  // Drive one instruction from FETCH to completion; rst_at names the path step where reset is injected.
  task automatic exec_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                            input int fw, input int mw, input int rst_at);
    int path[$];
    bit legal;
    case (op)
      LW:   path = '{0, 1, 2, 3, 4};
      SW:   path = '{0, 1, 2, 5};
      RT:   path = funct_legal(fn) ? '{0, 1, 6, 7} : '{0, 1, 6, 12, 12, 12, 12};
      BEQ:  path = '{0, 1, 8};
      ADDI: path = '{0, 1, 9, 10};
      JMP:  path = '{0, 1, 11};
      default: path = '{0, 1, 12, 12, 12, 12};
    endcase
    legal = (path[path.size()-1] != 12);
    for (int i = 0; i < path.size(); i++) begin
      int s, nw;
      s = path[i];
      nw = (s == 0) ? fw : ((s == 3 || s == 5) ? mw : 0);
      for (int w = 0; w <= nw; w++) begin
        logic [16:0] act, exp;
        logic rs;
        rs = (rst_at == i) && (w == nw);
        @(negedge clk);
        opcode = op;
        funct = fn;
        zero = (s == 8) ? z : 1'($urandom_range(0, 1));
        mem_ready = (s == 0 || s == 3 || s == 5) ? (w == nw) : 1'($urandom_range(0, 1));
        reset = rs;
        #1;
        n_cmp++;
        if (state !== 4'(s)) begin
          n_bad++;
          $display("FAIL state op=%b step=%0d: got %0d want %0d", op, i, state, s);
        end
        act = {pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
               alu_src_a, alu_src_b, alu_ctrl, pc_src, trap};
        exp = exp_out(s, mem_ready, zero, rs, fn);
        n_cmp++;
        if (act !== exp) begin
          n_bad++;
          $display("FAIL outputs op=%b st=%0d: got %b want %b", op, s, act, exp);
        end
        n_cmp++;
        if (retired !== 32'(model_ret)) begin
          n_bad++;
          $display("FAIL retired op=%b st=%0d: got %0d want %0d", op, s, retired, model_ret);
        end
        if (rs) begin
          model_ret = 0;
          return;
        end
      end
    end
    if (legal) model_ret++;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    mem_ready = 1'($urandom_range(0, 1));
    zero = 1'($urandom_range(0, 1));
    #1;
    n_cmp++;
    if ({pc_en, ir_write, mem_read, mem_write, reg_write} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_gating: got %b want 00000",
               {pc_en, ir_write, mem_read, mem_write, reg_write});
    end
    @(negedge clk);
    reset = 1'b0;
    mem_ready = 1'b0;
    #1;
    model_ret = 0;
    n_cmp++;
    if (state !== 4'd0 || retired !== 32'd0 || trap !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: got st=%0d ret=%0d trap=%b want 0 0 0", state, retired, trap);
    end
  endtask

  // Idle one cycle in FETCH and confirm the count after the preceding instruction.
  task automatic check_idle(input string tag);
    @(negedge clk);
    reset = 1'b0;
    mem_ready = 1'b0;
    #1;
    n_cmp++;
    if (state !== 4'd0 || retired !== 32'(model_ret)) begin
      n_bad++;
      $display("FAIL %s: got st=%0d ret=%0d want st=0 ret=%0d", tag, state, retired, model_ret);
    end
  endtask

  task automatic test_lw();
    exec_instr(LW, 6'h00, 1'b0, 0, 0, -1);
    check_idle("lw_retire");
  endtask

  task automatic test_rtype_sub();
    exec_instr(RT, 6'b100010, 1'b0, 0, 0, -1);
    check_idle("rtype_sub_retire");
  endtask

  task automatic test_beq();
    exec_instr(BEQ, 6'h00, 1'b0, 0, 0, -1);
    exec_instr(BEQ, 6'h00, 1'b1, 0, 0, -1);
    check_idle("beq_retire");
  endtask

  task automatic test_mem_wait();
    exec_instr(LW, 6'h00, 1'b0, 3, 2, -1);
    exec_instr(SW, 6'h00, 1'b0, 1, 3, -1);
    check_idle("mem_wait_retire");
  endtask

  task automatic test_trap();
    exec_instr(6'b111111, 6'h00, 1'b0, 0, 0, -1);
    check_trap_hold();
    test_reset();
    exec_instr(RT, 6'b000000, 1'b0, 1, 0, -1);
    check_trap_hold();
    test_reset();
  endtask

  task automatic check_trap_hold();
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    n_cmp++;
    if (state !== 4'd12 || trap !== 1'b1 || retired !== 32'(model_ret)) begin
      n_bad++;
      $display("FAIL trap_hold: got st=%0d trap=%b ret=%0d want 12 1 %0d",
               state, trap, retired, model_ret);
    end
  endtask

  task automatic test_reset_mid();
    exec_instr(ADDI, 6'h00, 1'b0, 0, 0, -1);
    exec_instr(LW, 6'h00, 1'b0, 0, 0, 4);
    check_idle("reset_mid_memwb");
  endtask

  task automatic test_random();
    logic [5:0] ops [6];
    logic [5:0] fns [5];
    ops = '{LW, SW, RT, BEQ, ADDI, JMP};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    for (int n = 0; n < 40; n++) begin
      exec_instr(ops[$urandom_range(0, 5)], fns[$urandom_range(0, 4)],
                 1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 2), -1);
    end
    check_idle("random_retire");
  endtask

  initial begin
    reset = 1'b1;
    zero = 1'b0;
    mem_ready = 1'b0;
    opcode = 6'h00;
    funct = 6'h00;
    test_reset();
    test_lw();
    test_rtype_sub();
    test_beq();
    test_mem_wait();
    test_trap();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
